commit_trace_buffer: RTL
========================

// Module: commit_trace_buffer
// PURPOSE
//  Sits directly downstream of the processor's MEM/WB commit port. Captures one record per
//  retired instruction (NPC, IR, dest idx, wr data, wr flag) into a FIFO for draining by a
//  trace consumer via valid/ready. Counts retired and dropped records. Detects the halt
//  instruction, drains the FIFO, then asserts done.
// PARAMETERS
//  DEPTH      16             FIFO entries; power of two, >=2
//  HALT_INSN  32'h00100073   IR encoding that ends the run (EBREAK)
// PORTS
//  clk                      in   1   clock, all state on posedge
//  rst                      in   1   synchronous reset, active-low
//  mem_wb_valid_inst        in   1   instruction retiring this cycle
//  mem_wb_IR                in   32  IR of retiring instruction
//  pipeline_commit_NPC      in   32  NPC of retiring instruction
//  pipeline_commit_wr       in   1   retiring instruction writes the RF
//  pipeline_commit_wr_idx   in   5   destination register
//  pipeline_commit_wr_data  in   32  value written
//  trace_valid              out  1   head record available
//  trace_ready              in   1   consumer accepts head record
//  trace_npc                out  32  head record NPC
//  trace_ir                 out  32  head record IR
//  trace_wr                 out  1   head record wr flag
//  trace_idx                out  5   head record idx
//  trace_data               out  32  head record data
//  retired_count            out  32  records pushed; wraps at 2^32
//  dropped_count            out  16  records lost to full FIFO; saturates at 16'hFFFF
//  halted                   out  1   halt instruction seen (sticky)
//  done                     out  1   halted and FIFO drained (sticky)
// BEHAVIOUR
//  - Reset (rst==0 at posedge): pointers, occupancy, both counters, halted and done -> 0.
//    State -> RUN. trace_valid = 0. Other trace_* = 0 (head storage cleared).
//  - Push condition: state==RUN && mem_wb_valid_inst. Record written at that posedge.
//    It is visible on trace_* from the next cycle: 1-cycle latency into an empty FIFO.
//  - Pop: trace_valid && trace_ready at posedge. trace_* reflect head combinationally from
//    registered storage.
//  - Full and push without pop: record dropped, dropped_count+1 (saturating).
//    retired_count is unchanged.
//  - Full with simultaneous push and pop: both take effect; no drop.
//  - Empty with simultaneous push and pop: the pop is ignored because trace_valid==0.
//    The push takes effect.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy counter is
//    log2(DEPTH)+1 bits.
//  - retired_count increments on every accepted push.
//  - State machine:
//    RUN   -> DRAIN when a push occurs with mem_wb_IR==HALT_INSN. halted=1 in the same edge.
//             The halt record itself is pushed, or dropped if the FIFO is full.
//    DRAIN -> no further pushes; mem_wb_valid_inst is ignored and counted nowhere.
//             Go to DONE when occupancy==0, or when occupancy==1 with a pop this cycle.
//    DONE  -> done=1; stays until reset. trace_valid=0.
//  - Reset mid-operation: all records are discarded immediately. Counters clear. The
//    consumer must not rely on records it has not yet accepted.
//  - pipeline_commit_wr_idx and wr_data are captured as given, even when wr==0.
//    Only the TRACE_SKIP_X0_EN filter alters them.
// CONFIGURATION
//  TRACE_SKIP_X0_EN defined:
//    - A retiring instruction with wr==1 && idx==0 is pushed with trace_wr forced to 0
//      and trace_data forced to 0.
//    - retired_count still increments.
//  Undefined: records are stored exactly as received.
// TESTING
//  1. Reset, then 3 retires, NPC 4/8/C, idx 1/2/3, data 11/22/33, trace_ready=1:
//     -> trace_valid rises 1 cycle after each push; records emerge in order;
//        retired_count=3.
//  2. trace_ready=0, 20 consecutive retires, DEPTH=16:
//     -> occupancy 16, dropped_count=4, retired_count=16.
//     Then ready=1 -> exactly 16 records emerge, NPCs equal the first 16 pushed.
//  3. FIFO full, push and pop in the same cycle:
//     -> dropped_count unchanged, occupancy stays 16, head advances by one.
//  4. Retire mem_wb_IR=32'h00100073 with 2 records already queued:
//     -> halted=1 next cycle. Later retires are not pushed.
//     done=1 the cycle after the 3rd record pops.
//  5. rst=0 for one cycle with 5 records queued and halted=1:
//     -> trace_valid=0, counters 0, halted=0, done=0.
//     A new retire then emerges normally.
//  6. With TRACE_SKIP_X0_EN: retire wr=1 idx=0 data=32'hDEAD -> trace_wr=0, trace_data=0.
//     Without the macro: trace_wr=1, trace_data=32'hDEAD.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: records each retired instruction into a FIFO drained over valid/ready,
// counts retired/dropped records and signals done once a halt has drained. Option: TRACE_SKIP_X0_EN.
module commit_trace_buffer #(
   parameter int          DEPTH     = 16,
   parameter logic [31:0] HALT_INSN = 32'h00100073
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_wb_valid_inst,
   input  logic [31:0] mem_wb_IR,
   input  logic [31:0] pipeline_commit_NPC,
   input  logic        pipeline_commit_wr,
   input  logic [4:0]  pipeline_commit_wr_idx,
   input  logic [31:0] pipeline_commit_wr_data,
   output logic        trace_valid,
   input  logic        trace_ready,
   output logic [31:0] trace_npc,
   output logic [31:0] trace_ir,
   output logic        trace_wr,
   output logic [4:0]  trace_idx,
   output logic [31:0] trace_data,
   output logic [31:0] retired_count,
   output logic [15:0] dropped_count,
   output logic        halted,
   output logic        done
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef struct packed {
      logic [31:0] npc;
      logic [31:0] ir;
      logic        wr;
      logic [4:0]  idx;
      logic [31:0] data;
   } rec_t;

   rec_t          mem_q [DEPTH];
   rec_t          mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   occ_q, occ_d;
   logic [31:0]   retired_q, retired_d;
   logic [15:0]   dropped_q, dropped_d;
   logic          halted_q, halted_d;
   logic          done_q, done_d;
   logic [1:0]    state_q, state_d;

   logic push_req, full, pop, accept, drop, skip_x0;
   rec_t new_rec, head;

   always_comb begin
      skip_x0 = 1'b0;
`ifdef TRACE_SKIP_X0_EN
      // Writes to x0 are architecturally invisible, so report them as non-writing.
      skip_x0 = pipeline_commit_wr && (pipeline_commit_wr_idx == 5'd0);
`endif
      new_rec.npc  = pipeline_commit_NPC;
      new_rec.ir   = mem_wb_IR;
      new_rec.wr   = pipeline_commit_wr && !skip_x0;
      new_rec.idx  = pipeline_commit_wr_idx;
      new_rec.data = skip_x0 ? 32'd0 : pipeline_commit_wr_data;
   end

   assign head        = mem_q[rd_ptr_q];
   assign trace_valid = (occ_q != '0) && (state_q != ST_DONE);
   assign trace_npc   = head.npc;
   assign trace_ir    = head.ir;
   assign trace_wr    = head.wr;
   assign trace_idx   = head.idx;
   assign trace_data  = head.data;

   assign retired_count = retired_q;
   assign dropped_count = dropped_q;
   assign halted        = halted_q;
   assign done          = done_q;

   assign push_req = (state_q == ST_RUN) && mem_wb_valid_inst;
   assign full     = (occ_q == FULL_OCC);
   assign pop      = trace_valid && trace_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign accept   = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;

   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      occ_d     = occ_q;
      retired_d = retired_q;
      dropped_d = dropped_q;
      halted_d  = halted_q;
      done_d    = done_q;
      state_d   = state_q;

      if (accept) begin
         mem_d[wr_ptr_q] = new_rec;
         wr_ptr_d        = wr_ptr_q + AW'(1);
         retired_d       = retired_q + 32'd1;
      end
      if (pop)
         rd_ptr_d = rd_ptr_q + AW'(1);
      case ({accept, pop})
         2'b10:   occ_d = occ_q + (AW+1)'(1);
         2'b01:   occ_d = occ_q - (AW+1)'(1);
         default: occ_d = occ_q;
      endcase
      if (drop && (dropped_q != 16'hFFFF))
         dropped_d = dropped_q + 16'd1;

      case (state_q)
         ST_RUN: begin
            if (push_req && (mem_wb_IR == HALT_INSN)) begin
               state_d  = ST_DRAIN;
               halted_d = 1'b1;
            end
         end
         ST_DRAIN: begin
            if ((occ_q == '0) || ((occ_q == (AW+1)'(1)) && pop)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_DONE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         occ_q     <= '0;
         retired_q <= '0;
         dropped_q <= '0;
         halted_q  <= 1'b0;
         done_q    <= 1'b0;
         state_q   <= ST_RUN;
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         occ_q     <= occ_d;
         retired_q <= retired_d;
         dropped_q <= dropped_d;
         halted_q  <= halted_d;
         done_q    <= done_d;
         state_q   <= state_d;
      end
   end
endmodule
